// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared encodings for the iterative multiply/divide unit.
//   MD_WIDTH   default operand / HI / LO width
//   md_op_t    MULT, MULTU, DIV, DIVU operation codes
//   state_t    sequencer states (IDLE, CALC, FIX)
package muldiv_unit_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   function automatic logic op_is_signed(md_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic op_is_div(md_op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: control-side bundle of the multiply/divide unit.
//   master : control unit (drives start/op/operands/MTHI/MTLO, reads busy/done/hi/lo)
//   slave  : muldiv_unit
//
// Handshake: start is a request that is accepted only on a clock edge where
// busy is low; there is no backpressure beyond busy and no queuing, so a start
// seen while busy is dropped. done is a single-cycle pulse marking the first
// cycle in which hi/lo hold the new result. hi_we/lo_we take effect only on
// edges where busy is low.
interface muldiv_unit_if
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
);
   logic             start;
   md_op_t           op;
   logic [WIDTH-1:0] busa;
   logic [WIDTH-1:0] busb;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, busa, busb, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, busa, busb, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit_negate.sv
// muldiv_negate: conditional two's-complement negation.
//   in_i   value
//   neg_i  1 = negate, 0 = pass through
//   out_o  result (W bits; -(-2^(W-1)) wraps to itself, which is what the
//          magnitude path wants when read as unsigned)
module muldiv_negate #(
   parameter int W = 32
) (
   input  logic [W-1:0] in_i,
   input  logic         neg_i,
   output logic [W-1:0] out_o
);
   assign out_o = neg_i ? (~in_i + {{(W-1){1'b0}}, 1'b1}) : in_i;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit with private HI/LO.
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   md           muldiv_unit_if.slave (start/op/busa/busb/hi_we/lo_we/wdata in,
//                busy/done/hi/lo out)
//   dbg_state_o  current sequencer state
// Launch edge captures operand magnitudes and result signs, WIDTH CALC
// cycles process one bit each on unsigned magnitudes, FIX applies signs and
// writes HI/LO, and done pulses the cycle after.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic    clk,
   input  logic    reset,
   muldiv_unit_if.slave md,
   output state_t  dbg_state_o
);
   localparam int CW = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // {remainder, quotient} for divide, {product high, product low} for multiply
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // multiplicand magnitude or divisor magnitude
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;  // negate product / quotient
   logic               neg_rem_q, neg_rem_d;  // remainder follows dividend sign
   logic               dz_q, dz_d;            // divide by zero
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;

   // Operand magnitudes at launch
   logic             sa, sb, launch_div;
   logic [WIDTH-1:0] abs_a, abs_b;
   assign launch_div = op_is_div(md.op);
   assign sa = op_is_signed(md.op) & md.busa[WIDTH-1];
   assign sb = op_is_signed(md.op) & md.busb[WIDTH-1];

   muldiv_negate #(.W(WIDTH)) u_abs_a (.in_i(md.busa), .neg_i(sa), .out_o(abs_a));
   muldiv_negate #(.W(WIDTH)) u_abs_b (.in_i(md.busb), .neg_i(sb), .out_o(abs_b));

   // Result sign fixups in FIX
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   muldiv_negate #(.W(2*WIDTH)) u_fix_prod (.in_i(acc_q), .neg_i(neg_res_q), .out_o(prod_fix));
   muldiv_negate #(.W(WIDTH)) u_fix_quo (.in_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .out_o(quo_fix));
   muldiv_negate #(.W(WIDTH)) u_fix_rem (.in_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .out_o(rem_fix));

   // Multiply step: add multiplicand into the high half when the multiplier
   // LSB is set, then shift the whole accumulator right with the carry.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide step: shift the next dividend bit into the partial remainder
   // (WIDTH+1 bits so nothing is lost) and subtract when it fits.
   logic [WIDTH:0]     div_shift, div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, opb_q};
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (md.hi_we) hi_d = md.wdata;
            if (md.lo_we) lo_d = md.wdata;
            if (md.start) begin
               state_d   = CALC;
               cnt_d     = CW'(WIDTH-1);
               is_div_d  = launch_div;
               neg_res_d = sa ^ sb;
               neg_rem_d = sa;
               dz_d      = launch_div && (md.busb == '0);
               acc_d     = {{WIDTH{1'b0}}, (launch_div ? abs_a : abs_b)};
               opb_d     = launch_div ? abs_b : abs_a;
            end
         end
         CALC: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
               // Divide by zero: quotient all ones; the remainder path
               // already reproduces the original dividend.
               hi_d = rem_fix;
               lo_d = dz_q ? {WIDTH{1'b1}} : quo_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign md.busy     = (state_q != IDLE);
   assign md.done     = done_q;
   assign md.hi       = hi_q;
   assign md.lo       = lo_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (directed + random ops,
// protocol corner cases, reset mid-operation).
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   reset;
   state_t dbg_state;
   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(W)) md_bus ();

   muldiv_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .md          (md_bus),
      .dbg_state_o (dbg_state)
   );

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q[$];
   logic [W-1:0] cur_hi, cur_lo;  // expected architectural HI/LO

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_model(md_op_t o, logic [31:0] a, logic [31:0] b);
      longint     la, lb;
      logic [63:0] ua, ub, res;
      int         ia, ib;
      res = '0;
      case (o)
         MD_MULT: begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            res = 64'(la * lb);
         end
         MD_MULTU: begin
            ua = {32'b0, a};
            ub = {32'b0, b};
            res = ua * ub;
         end
         MD_DIV: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
            else begin
               ia = $signed(a);
               ib = $signed(b);
               res = {32'(ia % ib), 32'(ia / ib)};
            end
         end
         default: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] specials [5];
      specials[0] = 32'h0;
      specials[1] = 32'h1;
      specials[2] = 32'hFFFF_FFFF;
      specials[3] = 32'h8000_0000;
      specials[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
      if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300));
      return $urandom;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      md_bus.start = 1'b0;
      md_bus.op    = MD_MULT;
      md_bus.busa  = '0;
      md_bus.busb  = '0;
      md_bus.hi_we = 1'b0;
      md_bus.lo_we = 1'b0;
      md_bus.wdata = '0;
   endtask

   // Launches one op, checks busy profile, latency and HI/LO.
   task automatic run_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_hi, input logic [31:0] e_lo, input string tag);
      logic [63:0] exp;
      bit seen, busy_ok;
      int lat;
      exp_q.push_back({e_hi, e_lo});
      @(negedge clk);
      md_bus.start = 1'b1;
      md_bus.op    = o;
      md_bus.busa  = a;
      md_bus.busb  = b;
      seen = 0; busy_ok = 1; lat = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         md_bus.start = 1'b0;
         md_bus.busa  = $urandom;  // operands must already be captured
         md_bus.busb  = $urandom;
         if (k <= W + 1) begin
            if (md_bus.busy !== 1'b1 || md_bus.done !== 1'b0) busy_ok = 0;
         end else if (md_bus.done === 1'b1) begin
            seen = 1; lat = k;
            if (md_bus.busy !== 1'b0) busy_ok = 0;
         end
      end
      exp = exp_q.pop_front();
      checks++;
      if (!seen || lat != W + 2) begin
         errors++;
         $display("FAIL %s latency: got %0d (seen=%0d) want %0d", tag, lat, seen, W + 2);
      end
      checks++;
      if (!busy_ok) begin
         errors++;
         $display("FAIL %s busy_profile: busy/done wrong during cycles 1..%0d", tag, W + 2);
      end
      checks++;
      if (md_bus.hi !== exp[63:32]) begin
         errors++;
         $display("FAIL %s hi: got %h want %h", tag, md_bus.hi, exp[63:32]);
      end
      checks++;
      if (md_bus.lo !== exp[31:0]) begin
         errors++;
         $display("FAIL %s lo: got %h want %h", tag, md_bus.lo, exp[31:0]);
      end
      cur_hi = exp[63:32];
      cur_lo = exp[31:0];
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      checks++;
      if (md_bus.busy !== 1'b0 || md_bus.done !== 1'b0 || md_bus.hi !== '0 ||
          md_bus.lo !== '0 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h state=%0d want 0/0/0/0/IDLE",
                  md_bus.busy, md_bus.done, md_bus.hi, md_bus.lo, dbg_state);
      end
      reset = 1'b0;
      cur_hi = '0;
      cur_lo = '0;
   endtask

   task automatic test_directed();
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
      run_op(MD_MULT,  32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");
      run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         "mult_min_sq");
      run_op(MD_DIVU,  32'd100,       32'd7,         32'h2,         32'hE,         "divu_100_7");
      run_op(MD_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
      run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, "div_overflow");
      run_op(MD_DIVU,  32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF, "divu_by_zero");
      run_op(MD_DIV,   32'hFFFF_FF00, 32'h0,         32'hFFFF_FF00, 32'hFFFF_FFFF, "div_by_zero_neg");
   endtask

   task automatic test_start_while_busy();
      int pulses;
      @(negedge clk);
      md_bus.start = 1'b1; md_bus.op = MD_MULTU; md_bus.busa = 32'd3; md_bus.busb = 32'd4;
      pulses = 0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         md_bus.start = (k == 5);
         if (k == 5) begin
            md_bus.busa = 32'd2;
            md_bus.busb = 32'd3;
         end
         if (md_bus.done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL start_busy_pulses: got %0d want 1", pulses);
      end
      checks++;
      if (md_bus.hi !== 32'h0 || md_bus.lo !== 32'd12) begin
         errors++;
         $display("FAIL start_busy_result: got %h_%h want 00000000_0000000c", md_bus.hi, md_bus.lo);
      end
      cur_hi = 32'h0;
      cur_lo = 32'd12;
   endtask

   task automatic test_mt_writes();
      // MTHI in IDLE
      @(negedge clk);
      md_bus.hi_we = 1'b1; md_bus.wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      md_bus.hi_we = 1'b0;
      checks++;
      if (md_bus.hi !== 32'hDEAD_BEEF || md_bus.lo !== cur_lo) begin
         errors++;
         $display("FAIL mthi_idle: got %h_%h want deadbeef_%h", md_bus.hi, md_bus.lo, cur_lo);
      end
      // MTHI+MTLO together
      md_bus.hi_we = 1'b1; md_bus.lo_we = 1'b1; md_bus.wdata = 32'h1357_9BDF;
      @(negedge clk);
      md_bus.hi_we = 1'b0; md_bus.lo_we = 1'b0;
      checks++;
      if (md_bus.hi !== 32'h1357_9BDF || md_bus.lo !== 32'h1357_9BDF) begin
         errors++;
         $display("FAIL mt_both: got %h_%h want 13579bdf_13579bdf", md_bus.hi, md_bus.lo);
      end
      // MTLO while busy is dropped; MTHI with start is honoured then overwritten
      md_bus.start = 1'b1; md_bus.op = MD_DIVU; md_bus.busa = 32'd100; md_bus.busb = 32'd7;
      md_bus.hi_we = 1'b1; md_bus.wdata = 32'hCAFE_F00D;
      @(negedge clk);
      md_bus.start = 1'b0; md_bus.hi_we = 1'b0;
      checks++;
      if (md_bus.hi !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL mthi_with_start: got %h want cafef00d", md_bus.hi);
      end
      repeat (8) @(negedge clk);
      md_bus.lo_we = 1'b1; md_bus.wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      md_bus.lo_we = 1'b0;
      checks++;
      if (md_bus.lo !== 32'h1357_9BDF) begin
         errors++;
         $display("FAIL mtlo_busy: got %h want 13579bdf", md_bus.lo);
      end
      begin
         bit seen;
         seen = 0;
         for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (md_bus.done === 1'b1) seen = 1;
         end
         checks++;
         if (!seen || md_bus.hi !== 32'h2 || md_bus.lo !== 32'hE) begin
            errors++;
            $display("FAIL mt_overwrite_result: seen=%0d got %h_%h want 00000002_0000000e",
                     seen, md_bus.hi, md_bus.lo);
         end
      end
      cur_hi = 32'h2;
      cur_lo = 32'hE;
   endtask

   task automatic test_random(input int n);
      md_op_t o;
      logic [31:0] a, b;
      logic [63:0] r;
      for (int i = 0; i < n; i++) begin
         o = md_op_t'($urandom_range(0, 3));
         a = pick_operand();
         b = pick_operand();
         r = ref_model(o, a, b);
         run_op(o, a, b, r[63:32], r[31:0], $sformatf("rand%0d_op%0d_%h_%h", i, o, a, b));
      end
   endtask

   task automatic test_reset_mid_op();
      int pulses;
      @(negedge clk);
      md_bus.start = 1'b1; md_bus.op = MD_DIV; md_bus.busa = 32'hFFFF_FFF9; md_bus.busb = 32'h2;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         md_bus.start = 1'b0;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (md_bus.busy !== 1'b0 || md_bus.hi !== '0 || md_bus.lo !== '0 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL reset_mid_op: busy=%b hi=%h lo=%h state=%0d want 0/0/0/IDLE",
                  md_bus.busy, md_bus.hi, md_bus.lo, dbg_state);
      end
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (md_bus.done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_no_done: got %0d done pulses want 0", pulses);
      end
      cur_hi = '0;
      cur_lo = '0;
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_directed();
      test_start_while_busy();
      test_mt_writes();
      test_random(40);
      test_reset_mid_op();
      run_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, "post_reset_mult");
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the general-purpose register file.
- Consumes the two register read buses (rs/rt operands) and implements MIPS MULT, MULTU, DIV, DIVU into private HI/LO registers.
- Also services MTHI/MTLO writes and supplies HI/LO to the writeback mux for MFHI/MFLO.
- Multi-cycle operation with a start/busy/done handshake toward the control unit, which stalls while busy.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  launch the operation given by op; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- busa  input  WIDTH  operand A (rs): multiplicand or dividend
- busb  input  WIDTH  operand B (rt): multiplier or divisor
- hi_we  input  1  MTHI: write wdata to HI
- lo_we  input  1  MTLO: write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress; control stalls MFHI/MFLO/new mul-div
- done  output  1  one-cycle pulse when HI/LO hold a new result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous, active-high, named reset. All registers are flopped on posedge clk or posedge reset.
- Reset: state IDLE; hi, lo, busy, done = 0; internal counter, accumulators and sign flags = 0.
- States:
  - IDLE → CALC on start.
  - CALC → FIX when the counter reaches 0.
  - FIX → IDLE, with done asserted.
- Launch (cycle 0, IDLE, start=1):
  - Latch op, the magnitudes |busa| and |busb| (signed ops only), and the result sign flags.
  - Counter = WIDTH-1.
- CALC, cycles 1..WIDTH, one bit per cycle:
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. The quotient bit is 1 when remainder ≥ divisor (unsigned compare on WIDTH+1 bits).
  - Counter decrements each cycle.
- FIX, cycle WIDTH+1:
  - Apply sign correction.
  - Multiply: negate the 2*WIDTH product if the operand signs differ.
  - Divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write HI (product high / remainder) and LO (product low / quotient) at the end of this cycle.
- Outputs:
  - busy = 1 in CALC and FIX (cycles 1..WIDTH+1), 0 otherwise.
  - done = 1 in cycle WIDTH+2 only; hi/lo are valid from that cycle.
  - Total latency from start to done is WIDTH+2 = 34 cycles.
- start while busy: ignored; no queuing.
- hi_we/lo_we:
  - In IDLE, the write occurs at that clock edge.
  - While busy, the write is ignored.
  - hi_we and lo_we together write wdata to both registers.
  - hi_we in the same cycle as start is honoured; the later result overwrites it.
- Operand capture: busa/busb are sampled only at the launch edge and may change freely afterwards.
- Divide by zero (defined, no trap): LO = all ones, HI = the original busa, for both DIV and DIVU.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. Magnitude arithmetic must handle |0x80000000| as unsigned.
- Reset mid-operation: immediate return to IDLE; HI/LO cleared; no done pulse.
- hi/lo are register outputs only; there is no combinational path from the inputs to them.

Decomposition:
- Shared package (cpu_pkg):
  - op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - State encodings: IDLE, CALC, FIX.
  - WIDTH default.
- Optional sub-module muldiv_negate: conditional two's-complement negation used for operand abs and result fixup. Everything else stays in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF → done at cycle 34, HI=0xFFFFFFFE, LO=0x00000001; busy high cycles 1–33.
- MULT 0xFFFFFFFD (-3) * 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 * 0x80000000 → HI=0x40000000, LO=0.
- DIVU 100 / 7 → LO=0x0000000E, HI=0x00000002. DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x00001234.
- Protocol:
  - start with MULTU 2*3 while busy during an earlier MULTU 3*4 → ignored; result HI=0, LO=12.
  - MTLO 0xA5A5A5A5 while busy → ignored. MTHI 0xDEADBEEF in IDLE → hi=0xDEADBEEF next cycle.
  - Reset asserted at cycle 10 of a DIV → busy=0, hi=lo=0 immediately; no done pulse.
